dispatch_buffer: RTL and testbench

Registered, parametrised dispatch stage of the Tomasulo back end. It sits between decode/register-status lookup and the issue queues (INT, MULT, DIV, LD/ST). It classifies each instruction and fixes up operand valid/data for x0, immediates and same-cycle CDB hits. Instructions are held in an in-order BUF_DEPTH buffer that keeps snooping the CDB while stalled, and they are released to the target queue with a valid/ready handshake. A branch-wait FSM replaces the external branch one-shot stall signals.

---
 rtl/dispatch_buffer_pkg.sv | 21 ++
 rtl/dispatch_buffer_if.sv | 41 ++++
 rtl/dispatch_buffer_classify.sv | 64 ++++++
 rtl/dispatch_buffer.sv | 182 ++++++++++++++++++
 tb/tb_dispatch_buffer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_buffer_pkg.sv
// Shared definitions for the dispatch stage: opcodes, queue classes, FSM states.
package dispatch_buffer_pkg;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_J_TYPE = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int DISP_NUM_Q = 4;

  // Encoding doubles as the q_valid bit index for the four real queues.
  typedef enum logic [2:0] {CLS_INT, CLS_MULT, CLS_DIV, CLS_LDST, CLS_NONE} disp_class_e;

  typedef enum logic {ST_RUN, ST_BR_WAIT} disp_state_e;

endpackage

// File: rtl/dispatch_buffer_if.sv
// Decode-side, CDB and issue-queue-side signals of the dispatch stage.
interface dispatch_buffer_if
  import dispatch_buffer_pkg::*;
#(parameter int DATA_W = 32, parameter int TAG_W = 6, parameter int BUF_DEPTH = 4);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic                  flush;
  logic                  dec_valid, dec_ready;
  logic [4:0]            rs1, rs2, rd;
  logic [DATA_W-1:0]     rs1_data, rs2_data, immediate;
  logic [TAG_W:0]        rs1_tag, rs2_tag;
  logic [TAG_W-1:0]      rd_tag;
  logic [6:0]            opcode, func7;
  logic [2:0]            func3;
  logic                  cdb_valid;
  logic [TAG_W-1:0]      cdb_tag;
  logic [DATA_W-1:0]     cdb_data;
  logic                  br_resolve;
  logic [DISP_NUM_Q-1:0] q_valid, q_ready;
  logic [6:0]            q_opcode, q_func7;
  logic [2:0]            q_func3;
  logic [DATA_W-1:0]     q_imm, q_rs1_data, q_rs2_data;
  logic                  q_rs1_valid, q_rs2_valid, q_wb_valid, q_is_store;
  logic [TAG_W:0]        q_rs1_tag, q_rs2_tag;
  logic [TAG_W-1:0]      q_rd_tag;
  logic [CW-1:0]         buf_count;

  modport master (
    output flush, dec_valid, rs1, rs2, rd, rs1_data, rs2_data, immediate, rs1_tag, rs2_tag,
           rd_tag, opcode, func3, func7, cdb_valid, cdb_tag, cdb_data, br_resolve, q_ready,
    input  dec_ready, q_valid, q_opcode, q_func3, q_func7, q_imm, q_rs1_data, q_rs1_valid,
           q_rs1_tag, q_rs2_data, q_rs2_valid, q_rs2_tag, q_rd_tag, q_wb_valid, q_is_store, buf_count
  );

  modport slave (
    input  flush, dec_valid, rs1, rs2, rd, rs1_data, rs2_data, immediate, rs1_tag, rs2_tag,
           rd_tag, opcode, func3, func7, cdb_valid, cdb_tag, cdb_data, br_resolve, q_ready,
    output dec_ready, q_valid, q_opcode, q_func3, q_func7, q_imm, q_rs1_data, q_rs1_valid,
           q_rs1_tag, q_rs2_data, q_rs2_valid, q_rs2_tag, q_rd_tag, q_wb_valid, q_is_store, buf_count
  );
endinterface

// File: rtl/dispatch_buffer_classify.sv
// Enqueue-time classification and operand fix-up (pure combinational).
module dispatch_classify
  import dispatch_buffer_pkg::*;
#(parameter int DATA_W = 32, parameter int TAG_W = 6) (
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic [4:0]        rs1, rs2, rd,
  input  logic [DATA_W-1:0] rs1_data, rs2_data, immediate,
  input  logic [TAG_W:0]    rs1_tag, rs2_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output disp_class_e       cls,
  output logic [DATA_W-1:0] rs1_d, rs2_d,
  output logic              rs1_v, rs2_v, wb_valid, is_branch, is_store
);

  // x0 reads as ready zero; a same-cycle broadcast wins over the pending tag.
  function automatic logic [DATA_W:0] fix_op(input logic [4:0] r, input logic [TAG_W:0] tag,
      input logic [DATA_W-1:0] d, input logic cv, input logic [TAG_W-1:0] ct,
      input logic [DATA_W-1:0] cd);
    if (r == 5'd0) return {1'b1, {DATA_W{1'b0}}};
    if (cv && tag[TAG_W] && (tag[TAG_W-1:0] == ct)) return {1'b1, cd};
    return {~tag[TAG_W], d};
  endfunction

  // Class, operand readiness and writeback flag from the decoded fields.
  always_comb begin
    cls = CLS_NONE;
    {rs1_v, rs1_d} = fix_op(rs1, rs1_tag, rs1_data, cdb_valid, cdb_tag, cdb_data);
    {rs2_v, rs2_d} = fix_op(rs2, rs2_tag, rs2_data, cdb_valid, cdb_tag, cdb_data);
    wb_valid  = 1'b0;
    is_branch = (opcode == OP_BRANCH) || (opcode == OP_JALR);
    is_store  = (opcode == OP_STORE);
    case (opcode)
      OP_R_TYPE: begin
        if (func7 == 7'd1 && func3 == 3'd0)      cls = CLS_MULT;
        else if (func7 == 7'd1 && func3 == 3'd4) cls = CLS_DIV;
        else                                     cls = CLS_INT;
        wb_valid = (rd != 5'd0);
      end
      OP_I_TYPE, OP_LUI: begin
        cls      = CLS_INT;
        rs2_d    = immediate;
        rs2_v    = 1'b1;
        wb_valid = (rd != 5'd0);
      end
      OP_JALR, OP_AUIPC: begin
        cls      = CLS_INT;
        wb_valid = (rd != 5'd0);
      end
      OP_BRANCH: cls = CLS_INT;
      OP_LOAD: begin
        cls      = CLS_LDST;
        rs2_v    = 1'b1;
        wb_valid = (rd != 5'd0);
      end
      OP_STORE: cls = CLS_LDST;
      default: cls = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/dispatch_buffer.sv
// In-order dispatch buffer: classify at enqueue, snoop CDB while held,
// release the head to its issue queue, stall behind unresolved branches.
module dispatch_buffer
  import dispatch_buffer_pkg::*;
#(parameter int DATA_W = 32, parameter int TAG_W = 6, parameter int BUF_DEPTH = 4,
  parameter bit BR_STALL = 1'b1) (
  input  logic            clk,
  input  logic            rst_n,
  dispatch_buffer_if.slave bus
);
  localparam int PW  = $clog2(BUF_DEPTH);
  localparam int CW  = PW + 1;
  localparam int TW1 = TAG_W + 1;
  // Flat entry layout, LSB first.
  localparam int O_ST   = 0;
  localparam int O_WB   = 1;
  localparam int O_RDT  = 2;
  localparam int O_RS2T = O_RDT + TAG_W;
  localparam int O_RS2V = O_RS2T + TW1;
  localparam int O_RS2D = O_RS2V + 1;
  localparam int O_RS1T = O_RS2D + DATA_W;
  localparam int O_RS1V = O_RS1T + TW1;
  localparam int O_RS1D = O_RS1V + 1;
  localparam int O_IMM  = O_RS1D + DATA_W;
  localparam int O_F7   = O_IMM + DATA_W;
  localparam int O_F3   = O_F7 + 7;
  localparam int O_OP   = O_F3 + 3;
  localparam int O_CLS  = O_OP + 7;
  localparam int ENT_W  = O_CLS + 3;

  logic [BUF_DEPTH-1:0][ENT_W-1:0] mem_q, mem_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  disp_state_e   state_q, state_d;

  disp_class_e       c_cls;
  logic [DATA_W-1:0] c_rs1_d, c_rs2_d;
  logic              c_rs1_v, c_rs2_v, c_wb, c_br, c_st;
  logic [ENT_W-1:0]  enq_ent, head;
  logic              empty, full, fire, accept, push, pop;

  function automatic logic snoop_hit(input logic v, input logic [TAG_W:0] tag,
      input logic cv, input logic [TAG_W-1:0] ct);
    return cv && !v && tag[TAG_W] && (tag[TAG_W-1:0] == ct);
  endfunction

  dispatch_classify #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_classify (
    .opcode(bus.opcode), .func3(bus.func3), .func7(bus.func7),
    .rs1(bus.rs1), .rs2(bus.rs2), .rd(bus.rd),
    .rs1_data(bus.rs1_data), .rs2_data(bus.rs2_data), .immediate(bus.immediate),
    .rs1_tag(bus.rs1_tag), .rs2_tag(bus.rs2_tag),
    .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag), .cdb_data(bus.cdb_data),
    .cls(c_cls), .rs1_d(c_rs1_d), .rs2_d(c_rs2_d), .rs1_v(c_rs1_v), .rs2_v(c_rs2_v),
    .wb_valid(c_wb), .is_branch(c_br), .is_store(c_st)
  );

  assign enq_ent = {c_cls, bus.opcode, bus.func3, bus.func7, bus.immediate,
                    c_rs1_d, c_rs1_v, bus.rs1_tag, c_rs2_d, c_rs2_v, bus.rs2_tag,
                    bus.rd_tag, c_wb, c_st};
  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(BUF_DEPTH));

  for (genvar k = 0; k < DISP_NUM_Q; k++) begin : g_qv
    assign bus.q_valid[k] = !empty && (head[O_CLS +: 3] == 3'(k));
  end

  assign fire          = |(bus.q_valid & bus.q_ready);
  assign bus.dec_ready = (state_q == ST_RUN) && (!full || fire);
  assign accept        = bus.dec_valid && bus.dec_ready && !bus.flush;
  assign push          = accept && (c_cls != CLS_NONE);
  assign pop           = fire && !bus.flush;
  assign bus.buf_count = count_q;

  // Head payload with same-cycle CDB bypass; zero when nothing is held.
  always_comb begin
    bus.q_opcode    = '0;
    bus.q_func3     = '0;
    bus.q_func7     = '0;
    bus.q_imm       = '0;
    bus.q_rs1_data  = '0;
    bus.q_rs1_valid = 1'b0;
    bus.q_rs1_tag   = '0;
    bus.q_rs2_data  = '0;
    bus.q_rs2_valid = 1'b0;
    bus.q_rs2_tag   = '0;
    bus.q_rd_tag    = '0;
    bus.q_wb_valid  = 1'b0;
    bus.q_is_store  = 1'b0;
    if (!empty) begin
      bus.q_opcode    = head[O_OP +: 7];
      bus.q_func3     = head[O_F3 +: 3];
      bus.q_func7     = head[O_F7 +: 7];
      bus.q_imm       = head[O_IMM +: DATA_W];
      bus.q_rs1_data  = head[O_RS1D +: DATA_W];
      bus.q_rs1_valid = head[O_RS1V];
      bus.q_rs1_tag   = head[O_RS1T +: TW1];
      bus.q_rs2_data  = head[O_RS2D +: DATA_W];
      bus.q_rs2_valid = head[O_RS2V];
      bus.q_rs2_tag   = head[O_RS2T +: TW1];
      bus.q_rd_tag    = head[O_RDT +: TAG_W];
      bus.q_wb_valid  = head[O_WB];
      bus.q_is_store  = head[O_ST];
      if (snoop_hit(head[O_RS1V], head[O_RS1T +: TW1], bus.cdb_valid, bus.cdb_tag)) begin
        bus.q_rs1_valid = 1'b1;
        bus.q_rs1_data  = bus.cdb_data;
      end
      if (snoop_hit(head[O_RS2V], head[O_RS2T +: TW1], bus.cdb_valid, bus.cdb_tag)) begin
        bus.q_rs2_valid = 1'b1;
        bus.q_rs2_data  = bus.cdb_data;
      end
    end
  end

  // Storage update: snoop live entries, write the new tail, move pointers.
  always_comb begin
    logic [PW-1:0] off;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if ({1'b0, off} < count_q) begin
        if (snoop_hit(mem_q[i][O_RS1V], mem_q[i][O_RS1T +: TW1], bus.cdb_valid, bus.cdb_tag)) begin
          mem_d[i][O_RS1V]          = 1'b1;
          mem_d[i][O_RS1D +: DATA_W] = bus.cdb_data;
        end
        if (snoop_hit(mem_q[i][O_RS2V], mem_q[i][O_RS2T +: TW1], bus.cdb_valid, bus.cdb_tag)) begin
          mem_d[i][O_RS2V]          = 1'b1;
          mem_d[i][O_RS2D +: DATA_W] = bus.cdb_data;
        end
      end
    end
    if (push) begin
      mem_d[wr_ptr_q] = enq_ent;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Branch-wait next state; flush always returns to RUN.
  always_comb begin
    state_d = state_q;
    if (bus.flush) state_d = ST_RUN;
    else begin
      case (state_q)
        ST_RUN:     if (BR_STALL && accept && c_br) state_d = ST_BR_WAIT;
        ST_BR_WAIT: if (bus.br_resolve)             state_d = ST_RUN;
        default:                                    state_d = ST_RUN;
      endcase
    end
  end

  // Branch-wait state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_dispatch_buffer;
  import dispatch_buffer_pkg::*;
  localparam int DW = 32, TW = 6, D = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  dispatch_buffer_if #(.DATA_W(DW), .TAG_W(TW), .BUF_DEPTH(D)) bus ();
  dispatch_buffer_if #(.DATA_W(DW), .TAG_W(TW), .BUF_DEPTH(D)) bus2 ();

  dispatch_buffer #(.DATA_W(DW), .TAG_W(TW), .BUF_DEPTH(D), .BR_STALL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  dispatch_buffer #(.DATA_W(DW), .TAG_W(TW), .BUF_DEPTH(D), .BR_STALL(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  int checks = 0, errors = 0;

  typedef struct {
    logic [2:0] cls; logic [6:0] op; logic [31:0] d1, d2; logic v1, v2;
    logic [6:0] t1, t2; logic [5:0] rdt; logic wb, st;
  } ent_t;
  ent_t mq[$];
  logic wait_m;

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic idle();
    bus.flush = 0; bus.dec_valid = 0; bus.rs1 = 0; bus.rs2 = 0; bus.rd = 0;
    bus.rs1_data = 0; bus.rs2_data = 0; bus.immediate = 0; bus.rs1_tag = 0; bus.rs2_tag = 0;
    bus.rd_tag = 0; bus.opcode = 0; bus.func3 = 0; bus.func7 = 0; bus.cdb_valid = 0;
    bus.cdb_tag = 0; bus.cdb_data = 0; bus.br_resolve = 0; bus.q_ready = 0;
    bus2.flush = 0; bus2.dec_valid = 0; bus2.rs1 = 0; bus2.rs2 = 0; bus2.rd = 0;
    bus2.rs1_data = 0; bus2.rs2_data = 0; bus2.immediate = 0; bus2.rs1_tag = 0; bus2.rs2_tag = 0;
    bus2.rd_tag = 0; bus2.opcode = 0; bus2.func3 = 0; bus2.func7 = 0; bus2.cdb_valid = 0;
    bus2.cdb_tag = 0; bus2.cdb_data = 0; bus2.br_resolve = 0; bus2.q_ready = 0;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
      input logic [6:0] t1, input logic [6:0] t2, input logic [5:0] rdt);
    bus.opcode = op; bus.func3 = f3; bus.func7 = f7; bus.rs1 = r1; bus.rs2 = r2; bus.rd = rd;
    bus.rs1_tag = t1; bus.rs2_tag = t2; bus.rd_tag = rdt;
    bus.rs1_data = 32'hA1; bus.rs2_data = 32'hB2; bus.immediate = 32'h1C;
  endtask

  // Reference: enqueue rules written straight from the instruction semantics.
  function automatic ent_t model_enq(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] d1,
      input logic [31:0] d2, input logic [31:0] imm, input logic [6:0] t1, input logic [6:0] t2,
      input logic [5:0] rdt, input logic cv, input logic [5:0] ct, input logic [31:0] cd);
    ent_t e;
    e.op = op; e.t1 = t1; e.t2 = t2; e.rdt = rdt; e.st = (op == OP_STORE);
    if (op == OP_R_TYPE) e.cls = (f7 == 1 && f3 == 0) ? 3'd1 : (f7 == 1 && f3 == 4) ? 3'd2 : 3'd0;
    else if (op == OP_I_TYPE || op == OP_BRANCH || op == OP_JALR || op == OP_LUI || op == OP_AUIPC) e.cls = 3'd0;
    else if (op == OP_LOAD || op == OP_STORE) e.cls = 3'd3;
    else e.cls = 3'd4;
    if (r1 == 0) begin e.v1 = 1; e.d1 = 0; end
    else if (cv && t1[6] && t1[5:0] == ct) begin e.v1 = 1; e.d1 = cd; end
    else begin e.v1 = !t1[6]; e.d1 = d1; end
    if (r2 == 0) begin e.v2 = 1; e.d2 = 0; end
    else if (cv && t2[6] && t2[5:0] == ct) begin e.v2 = 1; e.d2 = cd; end
    else begin e.v2 = !t2[6]; e.d2 = d2; end
    if (op == OP_I_TYPE || op == OP_LUI) begin e.v2 = 1; e.d2 = imm; end
    if (op == OP_LOAD) e.v2 = 1;
    e.wb = (rd != 0) && (op == OP_R_TYPE || op == OP_I_TYPE || op == OP_LOAD ||
                         op == OP_JALR || op == OP_LUI || op == OP_AUIPC);
    return e;
  endfunction

  task automatic test_reset();
    checks++; if (bus.q_valid !== 4'b0) begin errors++; $display("FAIL reset_qvalid: got %b exp 0000", bus.q_valid); end
    checks++; if (bus.buf_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", bus.buf_count); end
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", bus.dec_ready); end
    checks++; if (bus.q_opcode !== 7'd0) begin errors++; $display("FAIL reset_opcode: got %h exp 0", bus.q_opcode); end
    checks++; if (bus.q_rs1_data !== 32'd0) begin errors++; $display("FAIL reset_rs1data: got %h exp 0", bus.q_rs1_data); end
  endtask

  task automatic test_add();
    rst_n = 1;
    set_instr(OP_R_TYPE, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 7'h00, 7'h00, 6'd7);
    bus.dec_valid = 1; bus.q_ready = 4'hF; #1;
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL add_ready0: got %b exp 1", bus.dec_ready); end
    tick(); bus.dec_valid = 0; #1;
    checks++; if (bus.q_valid !== 4'b0001) begin errors++; $display("FAIL add_qvalid: got %b exp 0001", bus.q_valid); end
    checks++; if ({bus.q_rs1_valid, bus.q_rs2_valid, bus.q_wb_valid} !== 3'b111) begin errors++; $display("FAIL add_valids: got %b exp 111", {bus.q_rs1_valid, bus.q_rs2_valid, bus.q_wb_valid}); end
    checks++; if (bus.q_rs1_data !== 32'hA1) begin errors++; $display("FAIL add_rs1data: got %h exp a1", bus.q_rs1_data); end
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL add_ready1: got %b exp 1", bus.dec_ready); end
    tick();
    checks++; if (bus.buf_count !== 3'd0) begin errors++; $display("FAIL add_drain: got %0d exp 0", bus.buf_count); end
  endtask

  task automatic test_mul_order();
    idle(); bus.q_ready = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_instr(OP_R_TYPE, 3'd0, 7'd1, 5'd1, 5'd2, 5'd5, 7'h0, 7'h0, 6'd1);
      else        set_instr(OP_R_TYPE, 3'd0, 7'd0, 5'd1, 5'd2, 5'd6, 7'h0, 7'h0, 6'(i + 1));
      bus.dec_valid = 1; tick();
    end
    bus.dec_valid = 0; #1;
    checks++; if (bus.buf_count !== 3'd4) begin errors++; $display("FAIL mul_count: got %0d exp 4", bus.buf_count); end
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL mul_full_ready: got %b exp 0", bus.dec_ready); end
    checks++; if (bus.q_valid !== 4'b0010) begin errors++; $display("FAIL mul_block: got %b exp 0010", bus.q_valid); end
    bus.q_ready = 4'hF; #1;
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL mul_fire_ready: got %b exp 1", bus.dec_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.q_rd_tag !== 6'(i + 1)) begin errors++; $display("FAIL mul_order_tag: got %0d exp %0d", bus.q_rd_tag, i + 1); end
      checks++; if (bus.q_valid !== ((i == 0) ? 4'b0010 : 4'b0001)) begin errors++; $display("FAIL mul_order_q: got %b at %0d", bus.q_valid, i); end
      tick();
    end
    checks++; if (bus.buf_count !== 3'd0) begin errors++; $display("FAIL mul_drain: got %0d exp 0", bus.buf_count); end
  endtask

  task automatic test_snoop();
    idle(); set_instr(OP_R_TYPE, 3'd0, 7'h20, 5'd1, 5'd2, 5'd4, 7'h45, 7'h00, 6'd2);
    bus.dec_valid = 1; tick();
    bus.dec_valid = 0; bus.cdb_valid = 1; bus.cdb_tag = 6'd5; bus.cdb_data = 32'hDEADBEEF; #1;
    checks++; if (bus.q_rs1_valid !== 1'b1) begin errors++; $display("FAIL snoop_bypass_v: got %b exp 1", bus.q_rs1_valid); end
    tick(); bus.cdb_valid = 0; #1;
    checks++; if (bus.q_rs1_valid !== 1'b1) begin errors++; $display("FAIL snoop_held_v: got %b exp 1", bus.q_rs1_valid); end
    checks++; if (bus.q_rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL snoop_held_d: got %h exp deadbeef", bus.q_rs1_data); end
    bus.q_ready = 4'hF; #1;
    checks++; if (bus.q_valid !== 4'b0001) begin errors++; $display("FAIL snoop_release: got %b exp 0001", bus.q_valid); end
    tick();
    checks++; if (bus.buf_count !== 3'd0) begin errors++; $display("FAIL snoop_drain: got %0d exp 0", bus.buf_count); end
  endtask

  task automatic test_cdb_enq_dispatch();
    idle(); set_instr(OP_R_TYPE, 3'd0, 7'h20, 5'd1, 5'd2, 5'd4, 7'h45, 7'h00, 6'd8);
    bus.dec_valid = 1; bus.cdb_valid = 1; bus.cdb_tag = 6'd5; bus.cdb_data = 32'h12345678; tick();
    bus.cdb_valid = 0; set_instr(OP_R_TYPE, 3'd0, 7'h00, 5'd1, 5'd2, 5'd4, 7'h00, 7'h43, 6'd9);
    bus.q_ready = 4'hF; #1;
    checks++; if ({bus.q_rs1_valid, bus.q_rs1_data} !== {1'b1, 32'h12345678}) begin errors++; $display("FAIL cdb_enq: got %b/%h exp 1/12345678", bus.q_rs1_valid, bus.q_rs1_data); end
    tick(); bus.dec_valid = 0; bus.q_ready = 0; #1;
    checks++; if ({bus.q_rs2_valid, bus.q_rd_tag} !== {1'b0, 6'd9}) begin errors++; $display("FAIL cdb_pending: got %b/%0d exp 0/9", bus.q_rs2_valid, bus.q_rd_tag); end
    bus.cdb_valid = 1; bus.cdb_tag = 6'd3; bus.cdb_data = 32'hCAFEF00D; bus.q_ready = 4'hF; #1;
    checks++; if ({bus.q_rs2_valid, bus.q_rs2_data} !== {1'b1, 32'hCAFEF00D}) begin errors++; $display("FAIL cdb_dispatch: got %b/%h exp 1/cafef00d", bus.q_rs2_valid, bus.q_rs2_data); end
    checks++; if (bus.q_valid !== 4'b0001) begin errors++; $display("FAIL cdb_dispatch_q: got %b exp 0001", bus.q_valid); end
    tick(); bus.cdb_valid = 0; #1;
    checks++; if (bus.buf_count !== 3'd0) begin errors++; $display("FAIL cdb_drain: got %0d exp 0", bus.buf_count); end
  endtask

  task automatic test_branch();
    idle(); bus.q_ready = 4'hF;
    set_instr(OP_BRANCH, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 7'h0, 7'h0, 6'd3);
    bus.dec_valid = 1; bus2.opcode = OP_BRANCH; bus2.dec_valid = 1; #1;
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL br_ready_pre: got %b exp 1", bus.dec_ready); end
    tick(); bus.dec_valid = 0; bus2.dec_valid = 0; #1;
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL br_stall: got %b exp 0", bus.dec_ready); end
    checks++; if (bus2.dec_ready !== 1'b1) begin errors++; $display("FAIL br_nostall: got %b exp 1", bus2.dec_ready); end
    tick();
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL br_hold: got %b exp 0", bus.dec_ready); end
    bus.br_resolve = 1; #1;
    checks++; if (bus.dec_ready !== 1'b0) begin errors++; $display("FAIL br_resolve_cyc: got %b exp 0", bus.dec_ready); end
    tick(); bus.br_resolve = 0; #1;
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL br_release: got %b exp 1", bus.dec_ready); end
  endtask

  task automatic test_flush();
    idle(); set_instr(OP_R_TYPE, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 7'h0, 7'h0, 6'd1);
    bus.dec_valid = 1; tick(); tick(); tick();
    #1;
    checks++; if (bus.buf_count !== 3'd3) begin errors++; $display("FAIL flush_pre: got %0d exp 3", bus.buf_count); end
    bus.flush = 1; tick();
    bus.flush = 0; bus.dec_valid = 0; #1;
    checks++; if (bus.buf_count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d exp 0", bus.buf_count); end
    checks++; if (bus.q_valid !== 4'b0) begin errors++; $display("FAIL flush_qvalid: got %b exp 0000", bus.q_valid); end
    checks++; if (bus.dec_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", bus.dec_ready); end
  endtask

  task automatic test_reset_mid();
    idle(); set_instr(OP_R_TYPE, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 7'h0, 7'h0, 6'd1);
    bus.dec_valid = 1; tick(); tick(); tick();
    bus.dec_valid = 0; #1;
    checks++; if (bus.buf_count !== 3'd3) begin errors++; $display("FAIL rstmid_pre: got %0d exp 3", bus.buf_count); end
    #1 rst_n = 0; #1;
    checks++; if (bus.buf_count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d exp 0", bus.buf_count); end
    checks++; if (bus.q_valid !== 4'b0) begin errors++; $display("FAIL rstmid_qvalid: got %b exp 0000", bus.q_valid); end
    #1 rst_n = 1; tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    logic [2:0] f3; logic [6:0] f7, op, t1, t2; logic [4:0] r1, r2, rd; logic [5:0] rdt;
    logic [3:0] exp_qv; logic exp_fire, exp_rdy, has;
    ent_t h, e;
    ops = '{OP_R_TYPE, OP_R_TYPE, OP_I_TYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_LUI, OP_AUIPC, OP_J_TYPE};
    idle(); rst_n = 0; #2; rst_n = 1; tick();
    mq.delete(); wait_m = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      op = ($urandom_range(0, 19) == 0) ? 7'h7F : ops[$urandom_range(0, 9)];
      f3 = 3'($urandom_range(0, 7)); f7 = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) f3 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd4;
      r1 = 5'($urandom_range(0, 3)); r2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      t1 = {1'($urandom_range(0, 1)), 3'b0, 3'($urandom_range(0, 7))};
      t2 = {1'($urandom_range(0, 1)), 3'b0, 3'($urandom_range(0, 7))};
      rdt = 6'($urandom_range(0, 63));
      bus.opcode = op; bus.func3 = f3; bus.func7 = f7; bus.rs1 = r1; bus.rs2 = r2; bus.rd = rd;
      bus.rs1_tag = t1; bus.rs2_tag = t2; bus.rd_tag = rdt;
      bus.rs1_data = $urandom(); bus.rs2_data = $urandom(); bus.immediate = $urandom();
      bus.dec_valid = ($urandom_range(0, 3) != 0); bus.q_ready = 4'($urandom());
      bus.cdb_valid = 1'($urandom_range(0, 1)); bus.cdb_tag = 6'($urandom_range(0, 7)); bus.cdb_data = $urandom();
      bus.br_resolve = ($urandom_range(0, 5) == 0); bus.flush = ($urandom_range(0, 39) == 0);
      #1;
      has = (mq.size() > 0);
      exp_qv = 4'b0;
      if (has) begin
        h = mq[0];
        if (bus.cdb_valid && !h.v1 && h.t1[6] && h.t1[5:0] == bus.cdb_tag) begin h.v1 = 1; h.d1 = bus.cdb_data; end
        if (bus.cdb_valid && !h.v2 && h.t2[6] && h.t2[5:0] == bus.cdb_tag) begin h.v2 = 1; h.d2 = bus.cdb_data; end
        exp_qv = 4'b0001 << h.cls;
      end
      exp_fire = |(exp_qv & bus.q_ready);
      exp_rdy  = !wait_m && (mq.size() < D || exp_fire);
      checks++; if (bus.q_valid !== exp_qv) begin errors++; $display("FAIL rnd_qvalid c%0d: got %b exp %b", cyc, bus.q_valid, exp_qv); end
      checks++; if (bus.dec_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready c%0d: got %b exp %b", cyc, bus.dec_ready, exp_rdy); end
      checks++; if (bus.buf_count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count c%0d: got %0d exp %0d", cyc, bus.buf_count, mq.size()); end
      if (has) begin
        checks++; if ({bus.q_opcode, bus.q_rd_tag, bus.q_wb_valid, bus.q_is_store} !== {h.op, h.rdt, h.wb, h.st}) begin errors++; $display("FAIL rnd_ctrl c%0d: got %h/%0d/%b/%b exp %h/%0d/%b/%b", cyc, bus.q_opcode, bus.q_rd_tag, bus.q_wb_valid, bus.q_is_store, h.op, h.rdt, h.wb, h.st); end
        checks++; if ({bus.q_rs1_valid, bus.q_rs1_data, bus.q_rs1_tag} !== {h.v1, h.d1, h.t1}) begin errors++; $display("FAIL rnd_rs1 c%0d: got %b/%h/%h exp %b/%h/%h", cyc, bus.q_rs1_valid, bus.q_rs1_data, bus.q_rs1_tag, h.v1, h.d1, h.t1); end
        checks++; if ({bus.q_rs2_valid, bus.q_rs2_data, bus.q_rs2_tag} !== {h.v2, h.d2, h.t2}) begin errors++; $display("FAIL rnd_rs2 c%0d: got %b/%h/%h exp %b/%h/%h", cyc, bus.q_rs2_valid, bus.q_rs2_data, bus.q_rs2_tag, h.v2, h.d2, h.t2); end
      end
      if (bus.flush) begin
        mq.delete(); wait_m = 0;
      end else begin
        if (exp_fire) void'(mq.pop_front());
        if (bus.cdb_valid) begin
          for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            if (!e.v1 && e.t1[6] && e.t1[5:0] == bus.cdb_tag) begin e.v1 = 1; e.d1 = bus.cdb_data; end
            if (!e.v2 && e.t2[6] && e.t2[5:0] == bus.cdb_tag) begin e.v2 = 1; e.d2 = bus.cdb_data; end
            mq[i] = e;
          end
        end
        if (bus.dec_valid && exp_rdy) begin
          e = model_enq(op, f3, f7, r1, r2, rd, bus.rs1_data, bus.rs2_data, bus.immediate, t1, t2, rdt,
                        bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
          if (e.cls != 3'd4) mq.push_back(e);
          if (op == OP_BRANCH || op == OP_JALR) wait_m = 1;
        end else if (wait_m && bus.br_resolve) wait_m = 0;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle(); rst_n = 0; #12;
    test_reset();
    test_add();
    test_mul_order();
    test_snoop();
    test_cdb_enq_dispatch();
    test_branch();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
